// File: rtl/baudot_frame_rx_pkg.sv
// baudot_frame_rx_pkg: shared frame geometry and receiver state encoding.
package baudot_frame_rx_pkg;
  localparam int DATA_BITS = 5;
  localparam logic [2:0] TRAILER = 3'b010;
  localparam int TRAIL_LEN = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TRAIL, ST_STOP} state_t;
endpackage

// File: rtl/baudot_rx_shreg.sv
// baudot_rx_shreg: payload shift register; shifts in at the MSB so the first bit lands in bit 0.
module baudot_rx_shreg #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_shift) r_q <= {i_bit, r_q[WIDTH-1:1]};
  assign o_q = r_q;
endmodule

// File: rtl/baudot_frame_rx.sv
// baudot_frame_rx: fixed-length serial frame receiver (start, payload, trailer, stop).
module baudot_frame_rx #(
  parameter int         DATA_BITS = baudot_frame_rx_pkg::DATA_BITS,
  parameter logic [2:0] TRAILER   = baudot_frame_rx_pkg::TRAILER
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  import baudot_frame_rx_pkg::*;
  logic w_clk, w_rst_n, w_ser, w_en, w_unused;
  logic w_load, w_shift, w_last_data, w_last_trail;
  logic [1:0] w_tidx;
  logic [DATA_BITS-1:0] w_payload;
  logic [4:0] w_pay5;
  state_t r_state;
  logic r_rx_q, r_err, r_valid, r_ferr;
  logic [2:0] r_cnt;
  logic [4:0] r_data;
  assign w_clk    = io_in[0];
  assign w_rst_n  = io_in[1];
  assign w_ser    = io_in[2];
  assign w_en     = io_in[3];
  assign w_unused = &{1'b0, io_in[7:4]};
  assign w_load       = w_en && r_state == ST_IDLE && !r_rx_q;
  assign w_shift      = w_en && r_state == ST_DATA;
  assign w_last_data  = r_cnt == 3'(DATA_BITS - 1);
  assign w_last_trail = r_cnt == 3'(TRAIL_LEN - 1);
  // TRAILER is written first-bit-first, so the first trailer bit is its MSB
  assign w_tidx = 2'(TRAIL_LEN - 1) - r_cnt[1:0];
  assign w_pay5 = 5'(w_payload);
  baudot_rx_shreg #(.WIDTH(DATA_BITS)) u_shreg (
    .i_clk   (w_clk),
    .i_rst_n (w_rst_n),
    .i_load  (w_load),
    .i_d     ({DATA_BITS{1'b0}}),
    .i_shift (w_shift),
    .i_bit   (r_rx_q),
    .o_q     (w_payload)
  );
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_rx_q  <= 1'b1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx_q  <= w_ser;
      r_valid <= 1'b0;
      if (!w_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else case (r_state)
        ST_IDLE: if (!r_rx_q) begin
          r_state <= ST_DATA;
          r_cnt   <= '0;
          r_err   <= 1'b0;
        end
        ST_DATA: begin
          r_state <= w_last_data ? ST_TRAIL : ST_DATA;
          r_cnt   <= w_last_data ? 3'd0 : r_cnt + 3'd1;
        end
        ST_TRAIL: begin
          if (r_rx_q != TRAILER[w_tidx]) r_err <= 1'b1;
          r_state <= w_last_trail ? ST_STOP : ST_TRAIL;
          r_cnt   <= w_last_trail ? 3'd0 : r_cnt + 3'd1;
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          if (r_rx_q && !r_err) begin
            r_data  <= w_pay5;
            r_valid <= 1'b1;
            r_ferr  <= 1'b0;
          end else r_ferr <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign io_out = {r_state != ST_IDLE, r_ferr, r_valid, r_data};
endmodule

// File: tb/tb_baudot_frame_rx.sv
// tb_baudot_frame_rx: directed frames with hand-computed results for baudot_frame_rx.
module tb_baudot_frame_rx;
  logic clk = 1'b0, rst_n = 1'b1, ser = 1'b1, en = 1'b1;
  logic [7:0] io_in, io_out;
  int checks = 0, failures = 0, cyc = 0;
  int vq[$];
  logic [4:0] dq[$];
  assign io_in = {4'b1010, en, ser, rst_n, clk};
  baudot_frame_rx dut (.io_in(io_in), .io_out(io_out));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (io_out[5] === 1'b1) begin
      vq.push_back(cyc);
      dq.push_back(io_out[4:0]);
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic b);
    ser = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [4:0] d, input logic [2:0] tr, input logic stop);
    tick(1'b0);
    for (int i = 0; i < 5; i++) tick(d[i]);
    for (int i = 2; i >= 0; i--) tick(tr[i]);
    tick(stop);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_async_outputs", io_out, 0);
    @(posedge clk);
    #1 chk("reset_held_outputs", io_out, 0);
    rst_n = 1'b1;
    repeat (3) tick(1'b1);
    chk("idle_after_reset", io_out, 0);
    vq.delete(); dq.delete();
    send_frame(5'b01101, 3'b010, 1'b1);
    chk("f1_busy_in_stop", io_out[7], 1);
    chk("f1_no_early_valid", io_out[5], 0);
    tick(1'b1);
    chk("f1_valid", io_out[5], 1);
    chk("f1_data", io_out[4:0], 5'b01101);
    chk("f1_ferr", io_out[6], 0);
    chk("f1_busy_low", io_out[7], 0);
    tick(1'b1);
    chk("f1_valid_one_cycle", io_out[5], 0);
    chk("f1_pulse_count", vq.size(), 1);
    vq.delete(); dq.delete();
    send_frame(5'b00110, 3'b010, 1'b0);
    tick(1'b1);
    chk("badstop_ferr", io_out[6], 1);
    chk("badstop_data_held", io_out[4:0], 5'b01101);
    chk("badstop_no_valid", vq.size(), 0);
    send_frame(5'b00011, 3'b010, 1'b1);
    tick(1'b1);
    chk("recover_valid", io_out[5], 1);
    chk("recover_data", io_out[4:0], 5'b00011);
    chk("recover_ferr_clear", io_out[6], 0);
    tick(1'b1);
    vq.delete(); dq.delete();
    send_frame(5'b10101, 3'b000, 1'b1);
    tick(1'b1);
    chk("badtrail_ferr", io_out[6], 1);
    chk("badtrail_data_held", io_out[4:0], 5'b00011);
    chk("badtrail_no_valid", vq.size(), 0);
    vq.delete(); dq.delete();
    send_frame(5'b11111, 3'b010, 1'b1);
    send_frame(5'b00000, 3'b010, 1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("b2b_pulse_count", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_spacing", vq[1] - vq[0], 10);
      chk("b2b_first_data", dq[0], 5'b11111);
      chk("b2b_second_data", dq[1], 5'b00000);
    end
    chk("b2b_ferr_clear", io_out[6], 0);
    vq.delete(); dq.delete();
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    chk("abort_busy_before", io_out[7], 1);
    en = 1'b0;
    tick(1'b1);
    chk("abort_busy_low", io_out[7], 0);
    chk("abort_ferr_unchanged", io_out[6], 0);
    chk("abort_data_unchanged", io_out[4:0], 5'b00000);
    en = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("abort_no_valid", vq.size(), 0);
    send_frame(5'b10010, 3'b010, 1'b1);
    tick(1'b1);
    chk("post_abort_valid", io_out[5], 1);
    chk("post_abort_data", io_out[4:0], 5'b10010);
    chk("post_abort_ferr", io_out[6], 0);
    tick(1'b1);
    vq.delete(); dq.delete();
    tick(1'b0);
    for (int i = 0; i < 5; i++) tick(i[0]);
    tick(1'b0);
    tick(1'b1);
    chk("areset_busy_in_trail", io_out[7], 1);
    #2 rst_n = 1'b0;
    #1 chk("areset_outputs_zero", io_out, 0);
    #2 rst_n = 1'b1;
    tick(1'b0);
    tick(1'b1);
    repeat (12) tick(1'b1);
    chk("areset_no_valid", vq.size(), 0);
    chk("areset_data_zero", io_out[4:0], 5'b00000);
    send_frame(5'b01010, 3'b010, 1'b1);
    tick(1'b1);
    chk("final_valid", io_out[5], 1);
    chk("final_data", io_out[4:0], 5'b01010);
    chk("final_ferr", io_out[6], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baudot_frame_rx.md
BAUDOT_FRAME_RX -- requirements
Module: baudot_frame_rx

Interface
REQ-001 Parameter DATA_BITS, default 5, SHALL set the number of payload bits per frame.
REQ-002 Parameter TRAILER, default 3'b010, SHALL set the trailer pattern, listed in transmission order (first received bit first).
REQ-003 io_in[0]  input  1  clk; SHALL be the single clock; all state updates on its rising edge.
REQ-004 io_in[1]  input  1  rst_n; SHALL be the asynchronous, active-low reset.
REQ-005 io_in[2]  input  1  serial_in; SHALL carry the frame bit stream, one bit per clk, idle high.
REQ-006 io_in[3]  input  1  rx_en; when low, SHALL force the receiver to IDLE synchronously.
REQ-007 io_in[7:4]  input  4  SHALL be unused and ignored.
REQ-008 io_out[4:0]  output  5  data_out; SHALL hold the last good payload, bit 0 = first payload bit received.
REQ-009 io_out[5]  output  1  valid; SHALL be a one-cycle pulse when data_out updates.
REQ-010 io_out[6]  output  1  frame_error; SHALL be sticky until the next good frame.
REQ-011 io_out[7]  output  1  busy; SHALL be high whenever the state is not IDLE.

Function
REQ-012 Frame format, in time order: start 0, DATA_BITS payload bits LSB first, TRAILER bits, stop 1; any number of idle 1s SHALL be allowed between frames.
REQ-013 serial_in SHALL be registered once (rx_q); the FSM SHALL act only on rx_q.
REQ-014 States SHALL be IDLE, DATA, TRAIL and STOP.
REQ-015 IDLE: rx_q=0 SHALL go to DATA, clear bit counter and error flag; rx_q=1 SHALL stay in IDLE.
REQ-016 DATA: each cycle SHALL shift rx_q into the payload register at position cnt; after DATA_BITS cycles SHALL go to TRAIL with the counter cleared.
REQ-017 TRAIL: each cycle SHALL compare rx_q to the expected TRAILER bit and set the internal error flag on mismatch; after 3 cycles SHALL go to STOP.
REQ-018 TRAIL SHALL NOT abort early on mismatch; frame length SHALL be fixed.
REQ-019 STOP, rx_q=1 and error flag clear: SHALL load data_out, pulse valid for one cycle, clear frame_error, and go to IDLE.
REQ-020 STOP, rx_q=0 or error flag set: SHALL set frame_error, leave data_out unchanged, keep valid low, and go to IDLE.
REQ-021 Latency: valid SHALL assert on the second rising edge after the stop bit is present on serial_in (edge k captures it, edge k+1 updates outputs).
REQ-022 Back-to-back: a start bit on the cycle immediately after the stop bit SHALL be accepted with no idle gap.
REQ-023 rx_en low mid-frame SHALL return to IDLE with no valid and no frame_error change; the partial payload SHALL be discarded.
REQ-024 The bit counter SHALL be 3 bits wide and SHALL never exceed DATA_BITS-1 in DATA or 2 in TRAIL.

Reset
REQ-025 On rst_n low, all of the following SHALL take effect immediately, without a clock edge:
 - state = IDLE
 - rx_q = 1
 - counter = 0
 - payload = 0
 - data_out = 0
 - valid = 0
 - frame_error = 0
 - busy = 0
REQ-026 Reset deassertion SHALL take effect on the next clk edge; a frame already in flight at deassertion SHALL be ignored until a start bit is seen from IDLE.

Structure
REQ-027 A shared package SHALL hold DATA_BITS, TRAILER, the TRAILER length (3), and the state enum.
REQ-028 The payload shift register SHALL be one sub-module, baudot_rx_shreg, with load/shift enable and parallel output.
REQ-029 The FSM, counter and output registers SHALL live in baudot_frame_rx.
REQ-030 The RTL SHALL contain no latches and no combinational path from serial_in to any output.

Verification
REQ-031 Idle-to-frame: idle 1s, then 0,1,0,1,1,0,0,1,0,1 -> data_out=5'b01101 and valid pulses once, 2 edges after the stop bit; frame_error=0.
REQ-032 Bad trailer: payload 5'b10101 with trailer 0,0,0 and stop 1 -> valid stays 0, frame_error=1, data_out holds its previous value.
REQ-033 Bad stop: good frame with stop=0 -> frame_error=1; a following good frame with payload 5'b00011 -> data_out=5'b00011, valid pulses, frame_error=0.
REQ-034 Back-to-back: two frames (5'b11111 then 5'b00000) with no idle gap -> two valid pulses 10 cycles apart, both payloads correct.
REQ-035 Abort: rx_en dropped after the 3rd payload bit -> busy falls next cycle, no valid, frame_error unchanged; the next full frame is received normally.
REQ-036 Async reset: rst_n pulsed low mid-TRAIL, between clock edges -> all outputs 0 immediately; the remainder of the interrupted frame produces no valid pulse.
